// File: rtl/sdspi_pkg.sv
// Shared SD-card SPI init definitions: command indices, response types,
// failure codes, sequencer state/step enumerations and the per-step command table.
package sdspi_pkg;

  localparam logic [5:0] CMD_GO_IDLE      = 6'd0;
  localparam logic [5:0] CMD_SEND_IF_COND = 6'd8;
  localparam logic [5:0] CMD_CRC_ON_OFF   = 6'd59;
  localparam logic [5:0] CMD_APP          = 6'd55;
  localparam logic [5:0] ACMD_SD_SEND_OP  = 6'd41;
  localparam logic [5:0] CMD_READ_OCR     = 6'd58;

  localparam logic [1:0] RT_R1   = 2'b00;
  localparam logic [1:0] RT_R1B  = 2'b01;
  localparam logic [1:0] RT_R3R7 = 2'b10;

  localparam logic [3:0] ERR_NONE    = 4'd0;
  localparam logic [3:0] ERR_CMD0    = 4'd1;
  localparam logic [3:0] ERR_CMD8    = 4'd2;
  localparam logic [3:0] ERR_R1      = 4'd3;
  localparam logic [3:0] ERR_RETRY   = 4'd4;
  localparam logic [3:0] ERR_CMD58   = 4'd5;
  localparam logic [3:0] ERR_TIMEOUT = 4'd6;
  localparam logic [3:0] ERR_CMD59   = 4'd7;

  localparam logic [31:0] CMD8_ARG   = 32'h0000_01AA;
  localparam logic [31:0] ACMD41_HCS = 32'h4000_0000;
  localparam int          CMD0_TRIES = 8;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PREAMBLE, ST_ISSUE, ST_WAIT, ST_DONE, ST_ERROR
  } state_t;

  typedef enum logic [2:0] {
    STEP_CMD0, STEP_CMD8, STEP_CMD59, STEP_CMD55, STEP_ACMD41, STEP_CMD58
  } step_t;

  typedef struct packed {
    logic [1:0]  ctype;
    logic [5:0]  idx;
    logic [31:0] arg;
  } cmd_t;

  // Response type, index and argument for each step; v2 selects the HCS bit.
  function automatic cmd_t cmd_for_step(input step_t step, input logic v2);
    cmd_t c;
    c.ctype = RT_R1;
    c.idx   = CMD_GO_IDLE;
    c.arg   = 32'd0;
    case (step)
      STEP_CMD8: begin
        c.ctype = RT_R3R7;
        c.idx   = CMD_SEND_IF_COND;
        c.arg   = CMD8_ARG;
      end
      STEP_CMD59: begin
        c.idx = CMD_CRC_ON_OFF;
        c.arg = 32'd1;
      end
      STEP_CMD55: c.idx = CMD_APP;
      STEP_ACMD41: begin
        c.idx = ACMD_SD_SEND_OP;
        c.arg = v2 ? ACMD41_HCS : 32'd0;
      end
      STEP_CMD58: begin
        c.ctype = RT_R3R7;
        c.idx   = CMD_READ_OCR;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sdspi_timeout.sv
// Loadable saturating down-counter; o_expired is high whenever the count is zero.
module sdspi_timeout #(
  parameter int CNT_W = 21
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count <= '0;
    end else if (i_load) begin
      count <= i_load_val;
    end else if (i_en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign o_expired = (count == '0);

endmodule

// File: rtl/sdspi_init_seq.sv
// SD-card SPI-mode initialization sequencer: 0xFF preamble, CMD0/CMD8/CMD55/ACMD41/CMD58.
// Define SDSPI_INIT_CMD59_EN to insert CMD59 (CRC on) between CMD8 and CMD55.
module sdspi_init_seq
  import sdspi_pkg::*;
#(
  parameter int RETRY_LIMIT    = 1000,
  parameter int PREAMBLE_BYTES = 10,
  parameter int WAIT_TIMEOUT   = 2**20
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_ready,
  output logic        o_error,
  output logic [3:0]  o_err_code,
  output logic [31:0] o_ocr,
  output logic        o_sdhc,
  output logic        o_cmd_stb,
  output logic [1:0]  o_cmd_type,
  output logic [5:0]  o_cmd,
  output logic [31:0] o_cmd_data,
  input  logic        i_cmd_busy,
  input  logic        i_cmd_rxvalid,
  input  logic [39:0] i_cmd_response,
  output logic        o_pre_active,
  output logic        o_pre_stb,
  output logic [7:0]  o_pre_byte,
  input  logic        i_ll_busy
);

  localparam int PW = $clog2(PREAMBLE_BYTES + 1);
  localparam int RW = $clog2(RETRY_LIMIT + 1);
  localparam int TW = $clog2(WAIT_TIMEOUT + 1);

  localparam logic [PW-1:0] PRE_LAST  = PW'(PREAMBLE_BYTES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(RETRY_LIMIT - 1);
  localparam logic [TW-1:0] TMO_LOAD  = TW'(WAIT_TIMEOUT - 1);
  localparam logic [2:0]    CMD0_MAX  = 3'(CMD0_TRIES - 1);

`ifdef SDSPI_INIT_CMD59_EN
  localparam step_t STEP_AFTER_CMD8 = STEP_CMD59;
`else
  localparam step_t STEP_AFTER_CMD8 = STEP_CMD55;
`endif

  typedef enum logic [1:0] {BR_ISSUE, BR_ERR, BR_DONE} br_t;

  state_t          state;
  step_t           step;
  logic            v2;
  logic [PW-1:0]   pre_cnt;
  logic [RW-1:0]   retry_cnt;
  logic [2:0]      cmd0_tries;
  logic [39:0]     resp_r;
  logic            resp_pend;
  cmd_t            cmd_r;
  logic            cmd_accept;
  logic            tmo_expired;
  logic [7:0]      r1;

  br_t             br_kind;
  step_t           br_step;
  logic [3:0]      br_code;
  logic            br_v2;
  logic            br_cmd0_inc;
  logic            br_retry_inc;

  assign o_cmd_type = cmd_r.ctype;
  assign o_cmd      = cmd_r.idx;
  assign o_cmd_data = cmd_r.arg;
  assign o_pre_byte = 8'hFF;
  assign r1         = resp_r[39:32];
  assign cmd_accept = (state == ST_ISSUE) && o_cmd_stb && !i_cmd_busy;

  sdspi_timeout #(
    .CNT_W (TW)
  ) u_timeout (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (cmd_accept),
    .i_load_val (TMO_LOAD),
    .i_en       (state == ST_WAIT),
    .o_expired  (tmo_expired)
  );

  // Decision taken the cycle after a response was captured.
  always_comb begin
    br_kind      = BR_ERR;
    br_step      = step;
    br_code      = ERR_NONE;
    br_v2        = v2;
    br_cmd0_inc  = 1'b0;
    br_retry_inc = 1'b0;
    case (step)
      STEP_CMD0: begin
        if (r1 == 8'h01) begin
          br_kind = BR_ISSUE;
          br_step = STEP_CMD8;
        end else if (cmd0_tries >= CMD0_MAX) begin
          br_code = ERR_CMD0;
        end else begin
          br_kind     = BR_ISSUE;
          br_cmd0_inc = 1'b1;
        end
      end
      STEP_CMD8: begin
        if (r1[2]) begin
          br_kind = BR_ISSUE;
          br_step = STEP_AFTER_CMD8;
          br_v2   = 1'b0;
        end else if (resp_r[11:0] == 12'h1AA) begin
          br_kind = BR_ISSUE;
          br_step = STEP_AFTER_CMD8;
          br_v2   = 1'b1;
        end else begin
          br_code = ERR_CMD8;
        end
      end
`ifdef SDSPI_INIT_CMD59_EN
      STEP_CMD59: begin
        if (r1 <= 8'h01) begin
          br_kind = BR_ISSUE;
          br_step = STEP_CMD55;
        end else begin
          br_code = ERR_CMD59;
        end
      end
`endif
      STEP_CMD55: begin
        if (r1 <= 8'h01) begin
          br_kind = BR_ISSUE;
          br_step = STEP_ACMD41;
        end else begin
          br_code = ERR_R1;
        end
      end
      STEP_ACMD41: begin
        if (r1 == 8'h00) begin
          br_kind = BR_ISSUE;
          br_step = STEP_CMD58;
        end else if (r1 == 8'h01) begin
          if (retry_cnt >= RETRY_MAX) begin
            br_code = ERR_RETRY;
          end else begin
            br_kind      = BR_ISSUE;
            br_step      = STEP_CMD55;
            br_retry_inc = 1'b1;
          end
        end else begin
          br_code = ERR_R1;
        end
      end
      STEP_CMD58: begin
        if (r1 == 8'h00) br_kind = BR_DONE;
        else             br_code = ERR_CMD58;
      end
      default: br_code = ERR_CMD0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      step         <= STEP_CMD0;
      v2           <= 1'b0;
      pre_cnt      <= '0;
      retry_cnt    <= '0;
      cmd0_tries   <= '0;
      resp_r       <= '0;
      resp_pend    <= 1'b0;
      cmd_r        <= '0;
      o_busy       <= 1'b0;
      o_ready      <= 1'b0;
      o_error      <= 1'b0;
      o_err_code   <= ERR_NONE;
      o_ocr        <= '0;
      o_sdhc       <= 1'b0;
      o_cmd_stb    <= 1'b0;
      o_pre_active <= 1'b0;
      o_pre_stb    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (i_start) begin
            state        <= ST_PREAMBLE;
            o_busy       <= 1'b1;
            o_ready      <= 1'b0;
            o_error      <= 1'b0;
            o_err_code   <= ERR_NONE;
            o_pre_active <= 1'b1;
            o_pre_stb    <= 1'b1;
            pre_cnt      <= '0;
            retry_cnt    <= '0;
            cmd0_tries   <= '0;
            v2           <= 1'b0;
          end
        end
        ST_PREAMBLE: begin
          if (!i_ll_busy) begin
            if (pre_cnt == PRE_LAST) begin
              o_pre_active <= 1'b0;
              o_pre_stb    <= 1'b0;
              state        <= ST_ISSUE;
              step         <= STEP_CMD0;
              cmd_r        <= cmd_for_step(STEP_CMD0, v2);
              o_cmd_stb    <= 1'b1;
            end else begin
              pre_cnt <= pre_cnt + 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (cmd_accept) begin
            o_cmd_stb <= 1'b0;
            resp_pend <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (resp_pend) begin
            resp_pend <= 1'b0;
            case (br_kind)
              BR_ISSUE: begin
                state     <= ST_ISSUE;
                step      <= br_step;
                v2        <= br_v2;
                cmd_r     <= cmd_for_step(br_step, br_v2);
                o_cmd_stb <= 1'b1;
                if (br_cmd0_inc)  cmd0_tries <= cmd0_tries + 1'b1;
                if (br_retry_inc) retry_cnt  <= retry_cnt + 1'b1;
              end
              BR_DONE: begin
                state   <= ST_DONE;
                o_busy  <= 1'b0;
                o_ready <= 1'b1;
                o_ocr   <= resp_r[31:0];
                o_sdhc  <= resp_r[30];
              end
              default: begin
                state      <= ST_ERROR;
                o_busy     <= 1'b0;
                o_error    <= 1'b1;
                o_err_code <= br_code;
              end
            endcase
          end else if (i_cmd_rxvalid) begin
            resp_r    <= i_cmd_response;
            resp_pend <= 1'b1;
          end else if (tmo_expired) begin
            state      <= ST_ERROR;
            o_busy     <= 1'b0;
            o_error    <= 1'b1;
            o_err_code <= ERR_TIMEOUT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdspi_init_seq.sv
// Scoreboard bench for sdspi_init_seq: directed card-model scenarios, expected command stream queued.
module tb_sdspi_init_seq;

  localparam int RL = 4;
  localparam int PB = 10;
  localparam int WT = 64;

  logic        clk = 1'b0;
  logic        i_reset, i_start;
  logic        o_busy, o_ready, o_error, o_sdhc, o_cmd_stb;
  logic [3:0]  o_err_code;
  logic [31:0] o_ocr, o_cmd_data;
  logic [1:0]  o_cmd_type;
  logic [5:0]  o_cmd;
  logic        i_cmd_busy, i_cmd_rxvalid, i_ll_busy;
  logic [39:0] i_cmd_response;
  logic        o_pre_active, o_pre_stb;
  logic [7:0]  o_pre_byte;

  sdspi_init_seq #(.RETRY_LIMIT(RL), .PREAMBLE_BYTES(PB), .WAIT_TIMEOUT(WT)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
    .o_busy(o_busy), .o_ready(o_ready), .o_error(o_error), .o_err_code(o_err_code),
    .o_ocr(o_ocr), .o_sdhc(o_sdhc),
    .o_cmd_stb(o_cmd_stb), .o_cmd_type(o_cmd_type), .o_cmd(o_cmd), .o_cmd_data(o_cmd_data),
    .i_cmd_busy(i_cmd_busy), .i_cmd_rxvalid(i_cmd_rxvalid), .i_cmd_response(i_cmd_response),
    .o_pre_active(o_pre_active), .o_pre_stb(o_pre_stb), .o_pre_byte(o_pre_byte),
    .i_ll_busy(i_ll_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Card model configuration
  logic [7:0]  cmd0_r1;
  bit          cmd0_silent;
  logic [7:0]  cmd8_r1;
  logic [31:0] cmd8_pl;
  int          acmd41_ones;
  bit          acmd41_silent;
  logic [31:0] ocr_val;
  int          busy_hold;
  int          acmd41_seen;
  int          resp_delay;
  logic [39:0] resp_val;
  bit          stray;
  bit          ll_toggle;
  int          accept_cyc;
  int          end_cyc;

  // Scoreboard state
  logic [39:0] exp_q[$];
  int          pre_bytes;
  int          busy_checks;
  bit          first_arm;
  int          pre_first;

  function automatic logic [39:0] cmdv(input logic [1:0] t, input logic [5:0] i, input logic [31:0] a);
    return {t, i, a};
  endfunction

  task automatic cfg_default();
    cmd0_r1 = 8'h01; cmd0_silent = 0;
    cmd8_r1 = 8'h01; cmd8_pl = 32'h0000_01AA;
    acmd41_ones = 2; acmd41_silent = 0;
    ocr_val = 32'hC0FF_8000;
    busy_hold = 0; acmd41_seen = 0;
    ll_toggle = 0; pre_bytes = 0; busy_checks = 0;
  endtask

  task automatic push_prefix();
    exp_q.push_back(cmdv(2'b00, 6'd0, 32'h0));
    exp_q.push_back(cmdv(2'b10, 6'd8, 32'h0000_01AA));
`ifdef SDSPI_INIT_CMD59_EN
    exp_q.push_back(cmdv(2'b00, 6'd59, 32'h1));
`endif
  endtask

  task automatic push_app(input logic [31:0] arg);
    exp_q.push_back(cmdv(2'b00, 6'd55, 32'h0));
    exp_q.push_back(cmdv(2'b00, 6'd41, arg));
  endtask

  task automatic push_v2_full();
    push_prefix();
    for (int k = 0; k < 3; k++) push_app(32'h4000_0000);
    exp_q.push_back(cmdv(2'b10, 6'd58, 32'h0));
  endtask

  task automatic run_to_end(input string name);
    bit ok;
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (o_ready || o_error) begin ok = 1; end_cyc = cyc; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_end: no ready/error within 3000 cycles", name);
    end
  endtask

  // Card / command-engine model: drives inputs 1 time unit after each rising edge.
  initial begin
    i_cmd_busy = 0; i_cmd_rxvalid = 0; i_cmd_response = '0; i_ll_busy = 0;
    resp_delay = 0; stray = 0;
    forever begin
      @(posedge clk); #1;
      i_cmd_rxvalid = 1'b0;
      i_ll_busy = ll_toggle ? cyc[0] : 1'b0;
      if (stray) begin
        i_cmd_rxvalid = 1'b1;
        i_cmd_response = 40'hFF_DEAD_BEEF;
        stray = 0;
      end else if (i_reset) begin
        resp_delay = 0;
        i_cmd_busy = 1'b0;
      end else if (resp_delay > 0) begin
        resp_delay--;
        if (resp_delay == 0) begin
          i_cmd_rxvalid = 1'b1;
          i_cmd_response = resp_val;
        end
      end else if (o_cmd_stb) begin
        if (busy_hold > 0) begin
          i_cmd_busy = 1'b1;
          busy_hold--;
        end else begin
          i_cmd_busy = 1'b0;
          accept_cyc = cyc + 1;
          case (o_cmd)
            6'd0:  if (!cmd0_silent) begin resp_val = {cmd0_r1, 32'h0}; resp_delay = 3; end
            6'd8:  begin resp_val = {cmd8_r1, cmd8_pl}; resp_delay = 3; end
            6'd59: begin resp_val = {8'h00, 32'h0}; resp_delay = 3; end
            6'd55: begin resp_val = {8'h01, 32'h0}; resp_delay = 3; end
            6'd41: begin
              acmd41_seen++;
              if (!acmd41_silent) begin
                resp_val = {(acmd41_seen <= acmd41_ones) ? 8'h01 : 8'h00, 32'h0};
                resp_delay = 3;
              end
            end
            6'd58: begin resp_val = {8'h00, ocr_val}; resp_delay = 3; end
            default: ;
          endcase
        end
      end
    end
  end

  // Monitor: pops the expected command at every acceptance, checks stability while stalled.
  initial begin
    logic [39:0] cur, held, e;
    bit held_valid;
    held_valid = 0;
    forever begin
      @(negedge clk);
      cur = {o_cmd_type, o_cmd, o_cmd_data};
      if (o_cmd_stb && !i_cmd_busy && !i_reset) begin
        if (first_arm) begin pre_first = pre_bytes; first_arm = 0; end
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected_cmd: got 0x%0h, expected none", cur);
        end else begin
          e = exp_q.pop_front();
          check("sb_cmd", cur, e);
        end
      end
      if (o_cmd_stb && i_cmd_busy) begin
        if (held_valid) begin
          check("busy_stable", cur, held);
          busy_checks++;
        end
        held = cur;
        held_valid = 1;
      end else begin
        held_valid = 0;
      end
      if (o_pre_stb && !i_ll_busy) pre_bytes++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit got;
    first_arm = 0; pre_first = 0;
    cfg_default();
    i_reset = 1'b1; i_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_ready", o_ready, 0);
    check("rst_error", o_error, 0);
    check("rst_code", o_err_code, 0);
    check("rst_stb", o_cmd_stb, 0);
    check("rst_pre_active", o_pre_active, 0);
    check("rst_pre_byte", o_pre_byte, 8'hFF);
    i_reset = 1'b0;

    // v2 card, ACMD41 busy twice, SDHC OCR, byte port stalling every other cycle
    cfg_default(); ll_toggle = 1;
    push_v2_full();
    run_to_end("v2");
    check("v2_ready", o_ready, 1);
    check("v2_error", o_error, 0);
    check("v2_ocr", o_ocr, 32'hC0FF_8000);
    check("v2_sdhc", o_sdhc, 1);
    check("v2_busy", o_busy, 0);
    check("v2_pre_bytes", pre_bytes, PB);
    check("v2_acmd41_count", acmd41_seen, 3);
    check("v2_sb_empty", exp_q.size(), 0);

    // Stray response pulse in DONE must be ignored
    stray = 1;
    repeat (4) @(negedge clk);
    check("stray_ready", o_ready, 1);
    check("stray_ocr", o_ocr, 32'hC0FF_8000);
    check("stray_error", o_error, 0);

    // v1 card with the first command stalled by the engine for 5 cycles
    cfg_default();
    cmd8_r1 = 8'h05; cmd8_pl = 32'h0; acmd41_ones = 0; ocr_val = 32'h00FF_8000;
    busy_hold = 5;
    push_prefix();
    push_app(32'h0);
    exp_q.push_back(cmdv(2'b10, 6'd58, 32'h0));
    run_to_end("v1");
    check("v1_ready", o_ready, 1);
    check("v1_ocr", o_ocr, 32'h00FF_8000);
    check("v1_sdhc", o_sdhc, 0);
    check("v1_busy_checks", busy_checks, 4);
    check("v1_sb_empty", exp_q.size(), 0);

    // ACMD41 never ready: failure after exactly RL attempts
    cfg_default(); acmd41_ones = 100;
    push_prefix();
    for (int k = 0; k < RL; k++) push_app(32'h4000_0000);
    run_to_end("retry");
    check("retry_error", o_error, 1);
    check("retry_code", o_err_code, 4);
    check("retry_ready", o_ready, 0);
    check("retry_acmd41_count", acmd41_seen, RL);
    check("retry_sb_empty", exp_q.size(), 0);

    // Silent card on CMD0: timeout
    cfg_default(); cmd0_silent = 1;
    exp_q.push_back(cmdv(2'b00, 6'd0, 32'h0));
    run_to_end("tmo");
    check("tmo_code", o_err_code, 6);
    check("tmo_latency_le_64", ((end_cyc - accept_cyc) > 0) && ((end_cyc - accept_cyc) <= WT), 1);
    check("tmo_sb_empty", exp_q.size(), 0);

    // CMD0 never answers idle: 8 tries then code 1
    cfg_default(); cmd0_r1 = 8'h00;
    for (int k = 0; k < 8; k++) exp_q.push_back(cmdv(2'b00, 6'd0, 32'h0));
    run_to_end("cmd0");
    check("cmd0_code", o_err_code, 1);
    check("cmd0_sb_empty", exp_q.size(), 0);

    // CMD8 echo pattern wrong: code 2
    cfg_default(); cmd8_pl = 32'h0000_01AB;
    exp_q.push_back(cmdv(2'b00, 6'd0, 32'h0));
    exp_q.push_back(cmdv(2'b10, 6'd8, 32'h0000_01AA));
    run_to_end("cmd8");
    check("cmd8_code", o_err_code, 2);
    check("cmd8_sb_empty", exp_q.size(), 0);

    // Reset while waiting on ACMD41
    cfg_default(); acmd41_silent = 1;
    push_prefix();
    push_app(32'h4000_0000);
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    got = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (acmd41_seen == 1) begin got = 1; break; end
    end
    check("acmd41_reached", got, 1);
    repeat (5) @(posedge clk);
    #1 i_reset = 1'b1;
    @(posedge clk); #1;
    check("rst_wait_busy", o_busy, 0);
    check("rst_wait_error", o_error, 0);
    check("rst_wait_ocr", o_ocr, 0);
    check("rst_wait_sdhc", o_sdhc, 0);
    i_reset = 1'b0;
    check("rst_wait_sb_empty", exp_q.size(), 0);

    // Reset while a command is being offered: strobe drops on the next edge
    cfg_default(); busy_hold = 30;
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_cmd_stb) begin got = 1; break; end
    end
    check("stb_reached", got, 1);
    @(posedge clk); #1 i_reset = 1'b1;
    @(posedge clk); #1;
    check("rst_cmd_stb", o_cmd_stb, 0);
    i_reset = 1'b0; busy_hold = 0;
    check("rst_cmd_sb_empty", exp_q.size(), 0);

    // Clean restart after reset begins with the full preamble
    cfg_default();
    push_v2_full();
    first_arm = 1;
    run_to_end("restart");
    check("restart_ready", o_ready, 1);
    check("restart_pre_first", pre_first, PB);
    check("restart_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdspi_init_seq.md
SDSPI_INIT_SEQ -- requirements
Module: sdspi_init_seq

Interface
REQ-001 SHALL have parameter RETRY_LIMIT, default 1000, maximum ACMD41 attempts before failure.
REQ-002 SHALL have parameter PREAMBLE_BYTES, default 10, count of 0xFF bytes sent before CMD0.
REQ-003 SHALL have parameter WAIT_TIMEOUT, default 2^20, cycles allowed per command before failure.
REQ-004 SHALL have one clock i_clk; reset i_reset is synchronous and active-high.
REQ-005 SHALL have ports, in this order after clock and reset:
- i_start, in, 1: begin initialization
- o_busy, out, 1: sequence in progress
- o_ready, out, 1: card initialized
- o_error, out, 1: sequence failed
- o_err_code, out, 4: failure cause
- o_ocr, out, 32: captured OCR
- o_sdhc, out, 1: OCR[30]
- o_cmd_stb, out, 1: command request
- o_cmd_type, out, 2: 00=R1, 01=R1b, 10=R3/R7
- o_cmd, out, 6: command index
- o_cmd_data, out, 32: argument
- i_cmd_busy, in, 1: command engine busy
- i_cmd_rxvalid, in, 1: one-cycle response pulse
- i_cmd_response, in, 40: R1 in [39:32], payload in [31:0]
- o_pre_active, out, 1: byte-port mux select, preamble owns the port
- o_pre_stb, out, 1: preamble byte strobe
- o_pre_byte, out, 8: always 0xFF
- i_ll_busy, in, 1: byte port busy

Function
REQ-006 SHALL implement states IDLE, PREAMBLE, ISSUE, WAIT, DONE, ERROR; the current command is held in a step register: CMD0, CMD8, [CMD59], CMD55, ACMD41, CMD58.
REQ-007 SHALL accept i_start only in IDLE, DONE or ERROR; this clears o_ready, o_error and o_err_code, and enters PREAMBLE.
REQ-008 PREAMBLE SHALL:
- hold o_pre_active=1 and o_pre_stb=1;
- count one byte per cycle with !i_ll_busy;
- after PREAMBLE_BYTES bytes, drop both outputs and enter ISSUE at step CMD0.
REQ-009 ISSUE SHALL hold o_cmd_stb=1 with type, index and argument stable.
REQ-010 A command SHALL be accepted on the cycle o_cmd_stb && !i_cmd_busy; the next state is WAIT with o_cmd_stb=0.
REQ-011 WAIT SHALL capture i_cmd_response only on the i_cmd_rxvalid cycle and branch in the following cycle.
REQ-012 CMD0 (arg 0, type 00):
- R1==0x01 goes to CMD8;
- otherwise reissue CMD0, up to 8 tries total, then ERROR with code 1.
REQ-013 CMD8 (arg 0x000001AA, type 10):
- R1 bit2 set marks a v1 card and goes to CMD55;
- otherwise response[11:0] must equal 0x1AA, which marks a v2 card; else ERROR with code 2.
REQ-014 CMD55 (arg 0, type 00): R1 of 0x00 or 0x01 goes to ACMD41; any other value is ERROR with code 3.
REQ-015 ACMD41 (index 41, type 00, arg 0x40000000 for v2, 0 for v1):
- R1==0x00 goes to CMD58;
- R1==0x01 increments the retry count and returns to CMD55;
- count reaching RETRY_LIMIT is ERROR with code 4;
- any other R1 is ERROR with code 3.
REQ-016 CMD58 (arg 0, type 10):
- R1==0x00 loads o_ocr=response[31:0], sets o_sdhc=response[30], then DONE;
- otherwise ERROR with code 5.
REQ-017 The WAIT cycle counter SHALL restart on each acceptance; reaching WAIT_TIMEOUT is ERROR with code 6.
REQ-018 o_busy SHALL be 1 in PREAMBLE, ISSUE and WAIT, and 0 otherwise.
REQ-019 In DONE: o_ready=1; in ERROR: o_error=1 with the code held until the next start or reset.
REQ-020 Counters SHALL saturate and never wrap; an i_cmd_rxvalid pulse outside WAIT SHALL be ignored.

Reset
REQ-021 Reset SHALL force IDLE and zero all outputs, counters, o_ocr and o_sdhc, except o_pre_byte, which is constant 0xFF.
REQ-022 Reset mid-command SHALL drop o_cmd_stb in the next cycle.

Configuration
REQ-023 Macro SDSPI_INIT_CMD59_EN:
- when defined, CMD59 (arg 1, type 00) is issued after CMD8; R1 of 0x00 or 0x01 goes to CMD55, else ERROR with code 7;
- when undefined, CMD8 branches directly to CMD55 and code 7 never occurs.

Structure
REQ-024 A shared package sdspi_pkg SHALL hold the command indices, response-type codes, error codes and state/step enumerations.
REQ-025 One sub-module SHALL be used: sdspi_timeout, a loadable saturating down-counter with an expired flag.

Verification
REQ-026 Card model answers CMD0=01, CMD8=01/0x000001AA, ACMD41=01 twice then 00, CMD58 OCR 0xC0FF8000 -> o_ready=1, o_sdhc=1, o_ocr=0xC0FF8000, exactly 10 preamble bytes sent.
REQ-027 CMD8 R1=0x05 -> v1 path, ACMD41 argument 0x00000000.
REQ-028 ACMD41 always returns 0x01 with RETRY_LIMIT=4 -> o_error=1, o_err_code=4 after exactly 4 ACMD41 commands.
REQ-029 Model never answers CMD0, WAIT_TIMEOUT=64 -> code 6 within 64 cycles of acceptance.
REQ-030 i_reset mid-ACMD41 WAIT, then i_start -> clean restart beginning with the preamble.
REQ-031 i_cmd_busy held 5 cycles -> o_cmd_stb and argument remain stable, and the command is accepted exactly once.
